// File: rtl/snd_sched_pkg.sv
// Shared constants and helpers for the sound-side interrupt scheduler.
package snd_sched_pkg;

  localparam int unsigned CMD_W          = 8;
  localparam int unsigned INT_PERIOD_DEF = 16384;
  localparam int unsigned INT_HOLD_DEF   = 256;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  // Rising edge given the current level and its one-clk history.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/sndcmd_fifo.sv
// Sound command FIFO: synchronous push/pop, head reads 0 when empty.
// Push while full succeeds only if a pop happens in the same cycle.
module sndcmd_fifo
  import snd_sched_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [CMD_W-1:0]        data_i,
  output logic [CMD_W-1:0]        head_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snd_irq_sched.sv
// Sound CPU command mailbox (NMI) and periodic INT generator.
// Define SNDCMD_FIFO_EN to replace the single command latch with a FIFO.
module snd_irq_sched
  import snd_sched_pkg::*;
#(
  parameter int unsigned INT_PERIOD = INT_PERIOD_DEF,
  parameter int unsigned INT_HOLD   = INT_HOLD_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             cmd_wr,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             cmd_rd,
  output logic [CMD_W-1:0] cmd_q,
  output logic             cmd_pending,
  output logic             overrun,
  input  logic             frame_sync,
  output logic             nmireq,
  input  logic             nmiack,
  output logic             intreq,
  input  logic             intack
);

  localparam int unsigned CNT_W  = $clog2(INT_PERIOD);
  localparam int unsigned HOLD_W = $clog2(INT_HOLD + 1);

  if (INT_PERIOD < 2 || INT_HOLD < 1 || INT_HOLD >= INT_PERIOD ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("snd_irq_sched: illegal parameter combination");
  end

  // Edge detectors run every clk regardless of clk_en.
  logic cmd_wr_q, cmd_rd_q, nmiack_q, intack_q, frame_sync_q;
  logic wr_ev, rd_ev, nmiack_ev, intack_ev, sync_ev;

  assign wr_ev     = rise(cmd_wr, cmd_wr_q);
  assign rd_ev     = rise(cmd_rd, cmd_rd_q);
  assign nmiack_ev = rise(nmiack, nmiack_q);
  assign intack_ev = rise(intack, intack_q);
  assign sync_ev   = rise(frame_sync, frame_sync_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr_q     <= 1'b0;
      cmd_rd_q     <= 1'b0;
      nmiack_q     <= 1'b0;
      intack_q     <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      cmd_wr_q     <= cmd_wr;
      cmd_rd_q     <= cmd_rd;
      nmiack_q     <= nmiack;
      intack_q     <= intack;
      frame_sync_q <= frame_sync;
    end
  end

  // Periodic INT: frame_sync beats the wrap tick; a wrap re-arms the hold window.
  logic [CNT_W-1:0]  int_cnt_q, int_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              intreq_q, intreq_d;
  logic              int_wrap;

  always_comb begin
    int_cnt_d = int_cnt_q;
    hold_d    = hold_q;
    intreq_d  = intreq_q;
    int_wrap  = 1'b0;
    if (sync_ev) begin
      int_cnt_d = '0;
    end else if (clk_en) begin
      if (int_cnt_q == CNT_W'(INT_PERIOD - 1)) begin
        int_cnt_d = '0;
        int_wrap  = 1'b1;
      end else begin
        int_cnt_d = int_cnt_q + CNT_W'(1);
      end
    end
    if (int_wrap) begin
      intreq_d = 1'b1;
      hold_d   = '0;
    end else if (intreq_q) begin
      if (clk_en) hold_d = hold_q + HOLD_W'(1);
      if (intack_ev || (clk_en && hold_q == HOLD_W'(INT_HOLD - 1))) intreq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      int_cnt_q <= '0;
      hold_q    <= '0;
      intreq_q  <= 1'b0;
    end else begin
      int_cnt_q <= int_cnt_d;
      hold_q    <= hold_d;
      intreq_q  <= intreq_d;
    end
  end

  logic ovr_q, ovr_d;
  logic nmi_q, nmi_d;

`ifdef SNDCMD_FIFO_EN
  localparam int unsigned FC_W = $clog2(FIFO_DEPTH) + 1;

  logic [CMD_W-1:0] fifo_head;
  logic             fifo_empty, fifo_full;
  logic [FC_W-1:0]  fifo_count;
  logic             rearm_q, rearm_d;

  sndcmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_ev),
    .pop_i   (rd_ev),
    .data_i  (cmd_data),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // An ack with entries still queued re-raises NMI via a one-clk gap.
  always_comb begin
    ovr_d   = ovr_q;
    nmi_d   = nmi_q;
    rearm_d = 1'b0;
    if (wr_ev && fifo_full && !rd_ev) ovr_d = 1'b1;
    if (rearm_q) nmi_d = 1'b1;
    if (nmiack_ev) begin
      nmi_d   = 1'b0;
      rearm_d = !fifo_empty && !(rd_ev && fifo_count == FC_W'(1));
    end
    if (wr_ev) begin
      nmi_d   = 1'b1;
      rearm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q   <= 1'b0;
      nmi_q   <= 1'b0;
      rearm_q <= 1'b0;
    end else begin
      ovr_q   <= ovr_d;
      nmi_q   <= nmi_d;
      rearm_q <= rearm_d;
    end
  end

  assign cmd_q       = fifo_head;
  assign cmd_pending = !fifo_empty;
`else
  logic [CMD_W-1:0] cmd_q_q, cmd_q_d;
  logic             pend_q, pend_d;

  // A same-cycle read consumes the old byte first, so it never counts as overrun.
  always_comb begin
    cmd_q_d = cmd_q_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    nmi_d   = nmi_q;
    if (rd_ev) pend_d = 1'b0;
    if (nmiack_ev) nmi_d = 1'b0;
    if (wr_ev) begin
      cmd_q_d = cmd_data;
      pend_d  = 1'b1;
      nmi_d   = 1'b1;
      if (pend_q && !rd_ev) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q_q <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      nmi_q   <= 1'b0;
    end else begin
      cmd_q_q <= cmd_q_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      nmi_q   <= nmi_d;
    end
  end

  assign cmd_q       = cmd_q_q;
  assign cmd_pending = pend_q;
`endif

  assign overrun = ovr_q;
  assign nmireq  = nmi_q;
  assign intreq  = intreq_q;

endmodule
